// File: rtl/adc_frame_pkg.sv
// Shared types and defaults for the ADC frame sequencer.
package adc_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  typedef enum logic [2:0] {
    F_SYNC,
    F_SEQ,
    F_MASK,
    F_DATA,
    F_CSUM
  } field_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  function automatic int bytes_per_ch(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/frame_trigger_div.sv
// Frame-rate divider: counts 0..FRAME_DIV-1 while enabled, pulses trig_o on wrap.
module frame_trigger_div #(
  parameter int FRAME_DIV = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic trig_o
);

  localparam int CNT_W = $clog2(FRAME_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!enable_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign trig_o = enable_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/adc_frame_sequencer.sv
// Snapshots NUM_CH ADC channels per frame trigger and streams
// SYNC, SEQ, MASK, data, CSUM bytes over the tx_sys send/ready handshake.
module adc_frame_sequencer
  import adc_frame_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         DATA_W    = 8,
  parameter int         FRAME_DIV = 50000,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic                     changed_only_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]        ch_new_i,
  input  logic                     clear_err_i,
  input  logic                     tx_ready_i,
  output logic                     tx_send_o,
  output logic [7:0]               tx_data_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic [7:0]               seq_o,
  output logic                     skip_err_o
);

  localparam int BYTES = bytes_per_ch(DATA_W);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e                     state_q;
  field_e                     field_q;
  logic [CH_W-1:0]            ch_idx_q;
  logic                       byte_idx_q;
  logic [NUM_CH-1:0]          mask_q;
  logic [NUM_CH-1:0]          new_flags_q;
  logic [NUM_CH*DATA_W-1:0]   snap_q;
  logic [7:0]                 csum_q;
  logic [7:0]                 seq_q;
  logic [7:0]                 tx_data_q;
  logic                       tx_send_q;
  logic                       busy_q;
  logic                       frame_done_q;
  logic                       skip_err_q;

  logic                       trig;
  logic [NUM_CH-1:0]          mask_d;
  logic [NUM_CH-1:0]          flags_clr_d;
  logic [7:0]                 byte_d;
  logic [BYTES*8-1:0]         samp_ext_d;
  logic                       nxt_found_d;
  logic [CH_W-1:0]            nxt_ch_d;

  frame_trigger_div #(
    .FRAME_DIV(FRAME_DIV)
  ) u_div (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .enable_i(enable_i),
    .trig_o  (trig)
  );

  assign mask_d      = changed_only_i ? new_flags_q : {NUM_CH{1'b1}};
  assign flags_clr_d = (state_q == IDLE && trig) ? mask_d : '0;

  // Next set mask bit: lowest overall when leaving MASK, else lowest above ch_idx_q.
  always_comb begin
    nxt_found_d = 1'b0;
    nxt_ch_d    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (field_q == F_MASK || i > int'(ch_idx_q))) begin
        nxt_found_d = 1'b1;
        nxt_ch_d    = CH_W'(i);
      end
    end
  end

  always_comb begin
    samp_ext_d = '0;
    samp_ext_d[DATA_W-1:0] = snap_q[int'(ch_idx_q)*DATA_W +: DATA_W];
    case (field_q)
      F_SYNC:  byte_d = SYNC_BYTE;
      F_SEQ:   byte_d = seq_q;
      F_MASK:  byte_d = 8'(mask_q);
      F_DATA:  byte_d = samp_ext_d[(BYTES-1-int'(byte_idx_q))*8 +: 8];
      F_CSUM:  byte_d = csum_q;
      default: byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      field_q      <= F_SYNC;
      ch_idx_q     <= '0;
      byte_idx_q   <= 1'b0;
      mask_q       <= '0;
      new_flags_q  <= '0;
      snap_q       <= '0;
      csum_q       <= 8'h00;
      seq_q        <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_send_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      skip_err_q   <= 1'b0;
    end else begin
      tx_send_q    <= 1'b0;
      frame_done_q <= 1'b0;
      new_flags_q  <= (new_flags_q & ~flags_clr_d) | ch_new_i;

      if (trig && state_q != IDLE) begin
        skip_err_q <= 1'b1;
      end else if (clear_err_i) begin
        skip_err_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (trig) begin
            snap_q <= ch_data_i;
            mask_q <= mask_d;
            if (mask_d != '0) begin
              busy_q  <= 1'b1;
              state_q <= LATCH;
            end
          end
        end
        LATCH: begin
          field_q    <= F_SYNC;
          ch_idx_q   <= '0;
          byte_idx_q <= 1'b0;
          csum_q     <= 8'h00;
          state_q    <= SEND;
        end
        SEND: begin
          if (tx_ready_i) begin
            tx_data_q <= byte_d;
            tx_send_q <= 1'b1;
            if (field_q == F_SEQ || field_q == F_MASK || field_q == F_DATA) begin
              csum_q <= csum_q ^ byte_d;
            end
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!tx_ready_i) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_ready_i) begin
            state_q <= SEND;
            case (field_q)
              F_SYNC: field_q <= F_SEQ;
              F_SEQ:  field_q <= F_MASK;
              F_MASK: begin
                field_q    <= F_DATA;
                ch_idx_q   <= nxt_ch_d;
                byte_idx_q <= 1'b0;
              end
              F_DATA: begin
                if (int'(byte_idx_q) < BYTES - 1) begin
                  byte_idx_q <= 1'b1;
                end else if (nxt_found_d) begin
                  ch_idx_q   <= nxt_ch_d;
                  byte_idx_q <= 1'b0;
                end else begin
                  field_q <= F_CSUM;
                end
              end
              default: begin
                frame_done_q <= 1'b1;
                seq_q        <= seq_q + 8'd1;
                busy_q       <= 1'b0;
                state_q      <= IDLE;
              end
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_send_o    = tx_send_q;
  assign tx_data_o    = tx_data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign seq_o        = seq_q;
  assign skip_err_o   = skip_err_q;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Directed bench for adc_frame_sequencer: 4ch/8b instance plus a 1ch/10b instance.
module tb_adc_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        enable, changed_only, clear_err;
  logic        tx_ready = 1'b1;
  logic [31:0] ch_data;
  logic [3:0]  ch_new;
  logic        tx_send, busy, frame_done, skip_err;
  logic [7:0]  tx_data, seq;

  logic        enable1;
  logic        tx_ready1 = 1'b1;
  logic [9:0]  ch_data1;
  logic        tx_send1, busy1, frame_done1, skip_err1;
  logic [7:0]  tx_data1, seq1;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  got_q[$];
  logic [7:0]  got1_q[$];
  logic [7:0]  exp_q[$];
  int          rise_delay = 10;
  bit          hold_low = 1'b0;
  int          cnt = 0;
  int          cnt1 = 0;

  adc_frame_sequencer #(.NUM_CH(4), .DATA_W(8), .FRAME_DIV(64)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .changed_only_i(changed_only),
    .ch_data_i(ch_data), .ch_new_i(ch_new), .clear_err_i(clear_err), .tx_ready_i(tx_ready),
    .tx_send_o(tx_send), .tx_data_o(tx_data), .busy_o(busy), .frame_done_o(frame_done),
    .seq_o(seq), .skip_err_o(skip_err)
  );

  adc_frame_sequencer #(.NUM_CH(1), .DATA_W(10), .FRAME_DIV(64)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable1), .changed_only_i(1'b0),
    .ch_data_i(ch_data1), .ch_new_i(1'b0), .clear_err_i(1'b0), .tx_ready_i(tx_ready1),
    .tx_send_o(tx_send1), .tx_data_o(tx_data1), .busy_o(busy1), .frame_done_o(frame_done1),
    .seq_o(seq1), .skip_err_o(skip_err1)
  );

  // tx_sys model: drops ready after a send, raises it again rise_delay cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_ready = 1'b1;
      cnt = 0;
    end else if (tx_send) begin
      got_q.push_back(tx_data);
      tx_ready = 1'b0;
      cnt = rise_delay;
    end else if (cnt > 0) begin
      cnt--;
    end else if (!tx_ready && !hold_low) begin
      tx_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_ready1 = 1'b1;
      cnt1 = 0;
    end else if (tx_send1) begin
      got1_q.push_back(tx_data1);
      tx_ready1 = 1'b0;
      cnt1 = 10;
    end else if (cnt1 > 0) begin
      cnt1--;
    end else if (!tx_ready1) begin
      tx_ready1 = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cond(input int which, input int max, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      case (which)
        0: ok = busy;
        1: ok = frame_done;
        2: ok = busy1;
        3: ok = frame_done1;
        4: ok = (got_q.size() >= 5);
        default: ok = (got_q.size() >= 4);
      endcase
      if (ok) break;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic check_frame(input int which, input string tag);
    logic [7:0] g[$];
    logic [31:0] obs;
    if (which == 0) g = got_q;
    else g = got1_q;
    chk({tag, "_len"}, 32'(g.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < g.size()) ? 32'(g[i]) : 32'h100;
      chk($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
    end
  endtask

  task automatic run_frame(input string tag, input int max_done);
    enable = 1'b1;
    wait_cond(0, 200, {tag, "_busy_rise"});
    enable = 1'b0;
    wait_cond(1, max_done, {tag, "_frame_done"});
  endtask

  initial begin
    bit saw_busy;
    rst_n = 1'b0; enable = 1'b0; changed_only = 1'b0; clear_err = 1'b0;
    ch_data = '0; ch_new = '0; enable1 = 1'b0; ch_data1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_send", 32'(tx_send), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_seq", 32'(seq), 32'd0);
    chk("rst_skip_err", 32'(skip_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all channels, seq 0
    ch_data = {8'h44, 8'h33, 8'h22, 8'h11};
    got_q.delete();
    run_frame("t1", 2000);
    exp_q = '{8'hA5, 8'h00, 8'h0F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h4B};
    check_frame(0, "t1");
    chk("t1_seq", 32'(seq), 32'd1);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_skip_err", 32'(skip_err), 32'd0);

    // changed_only with a single fresh channel
    changed_only = 1'b1;
    ch_data[23:16] = 8'h5A;
    ch_new = 4'b0100;
    @(negedge clk);
    ch_new = 4'b0000;
    got_q.delete();
    run_frame("t2", 2000);
    exp_q = '{8'hA5, 8'h01, 8'h04, 8'h5A, 8'h5F};
    check_frame(0, "t2");
    chk("t2_seq", 32'(seq), 32'd2);
    got_q.delete();
    saw_busy = 1'b0;
    enable = 1'b1;
    repeat (80) begin
      @(negedge clk);
      saw_busy |= busy;
    end
    enable = 1'b0;
    chk("t2_empty_busy", 32'(saw_busy), 32'd0);
    chk("t2_empty_sends", 32'(got_q.size()), 32'd0);
    chk("t2_empty_seq", 32'(seq), 32'd2);

    // 10-bit single channel: two bytes MSB first
    ch_data1 = 10'h3FF;
    enable1 = 1'b1;
    wait_cond(2, 200, "t3_busy_rise");
    enable1 = 1'b0;
    wait_cond(3, 2000, "t3_frame_done");
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h03, 8'hFF, 8'hFD};
    check_frame(1, "t3");
    chk("t3_seq", 32'(seq1), 32'd1);

    // slow transmitter: triggers land while busy
    changed_only = 1'b0;
    rise_delay = 30;
    got_q.delete();
    enable = 1'b1;
    wait_cond(0, 200, "t4_busy_rise");
    repeat (80) @(negedge clk);
    enable = 1'b0;
    wait_cond(1, 4000, "t4_frame_done");
    exp_q = '{8'hA5, 8'h02, 8'h0F, 8'h11, 8'h22, 8'h5A, 8'h44, 8'h20};
    check_frame(0, "t4");
    chk("t4_seq", 32'(seq), 32'd3);
    chk("t4_skip_set", 32'(skip_err), 32'd1);
    repeat (150) @(negedge clk);
    chk("t4_seq_after", 32'(seq), 32'd3);
    chk("t4_busy_after", 32'(busy), 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("t4_skip_clr", 32'(skip_err), 32'd0);
    rise_delay = 10;

    // reset in the middle of data byte 2
    got_q.delete();
    enable = 1'b1;
    wait_cond(0, 200, "t5_busy_rise");
    enable = 1'b0;
    wait_cond(4, 400, "t5_reach_byte");
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_send", 32'(tx_send), 32'd0);
    chk("t5_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_seq", 32'(seq), 32'd0);
    chk("t5_rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    run_frame("t5", 2000);
    exp_q = '{8'hA5, 8'h00, 8'h0F, 8'h11, 8'h22, 8'h5A, 8'h44, 8'h22};
    check_frame(0, "t5");

    // transmitter stalls with ready low, then recovers
    got_q.delete();
    enable = 1'b1;
    wait_cond(0, 200, "t6_busy_rise");
    enable = 1'b0;
    wait_cond(5, 400, "t6_reach_byte");
    hold_low = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_stall_sends", 32'(got_q.size()), 32'd4);
    chk("t6_stall_busy", 32'(busy), 32'd1);
    chk("t6_stall_tx_send", 32'(tx_send), 32'd0);
    hold_low = 1'b0;
    wait_cond(1, 2000, "t6_frame_done");
    exp_q = '{8'hA5, 8'h01, 8'h0F, 8'h11, 8'h22, 8'h5A, 8'h44, 8'h23};
    check_frame(0, "t6");
    chk("t6_seq", 32'(seq), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
